// File: rtl/flappy_pkg.sv
// Shared types and helpers for the flappy-bird button conditioner.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;

  // Bits needed to hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flappy_debounce.sv
// One button: synchroniser, debounce FSM, debounce timer and hold-to-repeat.
//   state      | meaning
//   IDLE       | button released and stable
//   PRESS_WAIT | raw level high, waiting for it to stay high
//   HELD       | press accepted, button down
//   REL_WAIT   | raw level low, waiting for it to stay low
module flappy_debounce
  import flappy_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 15,
  parameter int REPEAT_PERIOD   = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn,
  input  logic frame_tick,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int FR_W = cnt_width(REPEAT_DELAY + 1);
  localparam int PR_W = cnt_width(REPEAT_PERIOD);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PR_W-1:0] PR_LOAD = PR_W'(REPEAT_PERIOD - 1);
  localparam logic [FR_W-1:0] FR_SAT  = FR_W'(REPEAT_DELAY);
  localparam logic [FR_W-1:0] FR_HIT  = FR_W'(REPEAT_DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   hold;
  btn_state_t             state, state_nxt;
  logic [DB_W-1:0]        db_cnt;
  logic                   db_zero;
  logic [FR_W-1:0]        fr_cnt;
  logic [PR_W-1:0]        pr_cnt;
  logic                   fr_reached;

  assign hold     = rst | ~ena;
  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign db_zero  = (db_cnt == '0);

  // The synchroniser keeps sampling while disabled; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  always_ff @(posedge clk) begin
    if (hold) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (sync_bit) state_nxt = PRESS_WAIT;
      PRESS_WAIT: if (!sync_bit) state_nxt = IDLE;
                  else if (db_zero) state_nxt = HELD;
      HELD:       if (!sync_bit) state_nxt = REL_WAIT;
      REL_WAIT:   if (sync_bit) state_nxt = HELD;
                  else if (db_zero) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level = 1'b0;
    press = 1'b0;
    rel   = 1'b0;
    if (!hold) begin
      level = (state == HELD) || (state == REL_WAIT);
      press = (state == PRESS_WAIT) && sync_bit && db_zero;
      rel   = (state == REL_WAIT) && !sync_bit && db_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      db_cnt <= '0;
    end else if (((state == IDLE) && sync_bit) || ((state == HELD) && !sync_bit)) begin
      db_cnt <= DB_LOAD;
    end else if (((state == PRESS_WAIT) || (state == REL_WAIT)) && !db_zero) begin
      db_cnt <= db_cnt - 1'b1;
    end
  end

  // Frame counter saturates at the delay; a period timer takes over from there.
  assign fr_reached = (fr_cnt == FR_SAT);
  assign rpt = frame_tick & level &
               ((!fr_reached && (fr_cnt == FR_HIT)) || (fr_reached && (pr_cnt == '0)));

  always_ff @(posedge clk) begin
    if (hold || !level) begin
      fr_cnt <= '0;
      pr_cnt <= '0;
    end else if (frame_tick) begin
      if (!fr_reached) begin
        fr_cnt <= fr_cnt + 1'b1;
        if (fr_cnt == FR_HIT) pr_cnt <= PR_LOAD;
      end else if (pr_cnt == '0) begin
        pr_cnt <= PR_LOAD;
      end else begin
        pr_cnt <= pr_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/flappy_input_cond.sv
// Button conditioner for the flappy-bird core: per-button debounce plus
// frame-aligned up/down commands built from per-button pending flags.
module flappy_input_cond
  import flappy_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 15,
  parameter int REPEAT_PERIOD   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               frame_tick_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_press_o,
  output logic [NUM_BTN-1:0] btn_release_o,
  output logic               cmd_up_o,
  output logic               cmd_down_o
);

  logic [NUM_BTN-1:0] rpt;
  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] pend_eff;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    flappy_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .btn        (btn_i[g]),
      .frame_tick (frame_tick_i),
      .level      (btn_level_o[g]),
      .press      (btn_press_o[g]),
      .rel        (btn_release_o[g]),
      .rpt        (rpt[g])
    );
  end

  // A press or repeat landing on the tick cycle is folded into that tick.
  assign pend_eff = pend | btn_press_o | rpt;

  always_ff @(posedge clk) begin
    if (rst || !ena)       pend <= '0;
    else if (frame_tick_i) pend <= '0;
    else                   pend <= pend_eff;
  end

  assign cmd_up_o   = ~rst & ena & frame_tick_i & pend_eff[BTN_UP]   & ~pend_eff[BTN_DOWN];
  assign cmd_down_o = ~rst & ena & frame_tick_i & pend_eff[BTN_DOWN] & ~pend_eff[BTN_UP];

endmodule

// File: tb/tb_flappy_input_cond.sv
// Directed bench for flappy_input_cond with short debounce/repeat settings.
module tb_flappy_input_cond;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] btn_i;
  logic       frame_tick_i;
  logic [1:0] btn_level_o;
  logic [1:0] btn_press_o;
  logic [1:0] btn_release_o;
  logic       cmd_up_o;
  logic       cmd_down_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int press_cnt0 = 0;
  int press_cnt1 = 0;
  int rel_cnt0 = 0;
  int press_cyc0 = 0;

  flappy_input_cond #(
    .NUM_BTN         (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (3),
    .REPEAT_PERIOD   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .btn_i         (btn_i),
    .frame_tick_i  (frame_tick_i),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .cmd_up_o      (cmd_up_o),
    .cmd_down_o    (cmd_down_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (btn_press_o[0]) begin
      press_cnt0 <= press_cnt0 + 1;
      press_cyc0 <= cyc;
    end
    if (btn_press_o[1])   press_cnt1 <= press_cnt1 + 1;
    if (btn_release_o[0]) rel_cnt0 <= rel_cnt0 + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ena = 1'b1;
    btn_i = 2'b00;
    frame_tick_i = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
  endtask

  task automatic do_tick(output logic up, output logic down);
    frame_tick_i = 1'b1;
    @(negedge clk);
    up = cmd_up_o;
    down = cmd_down_o;
    @(posedge clk);
    #1;
    frame_tick_i = 1'b0;
  endtask

  task automatic test_reset();
    int t0, p0;
    rst = 1'b1;
    ena = 1'b1;
    btn_i = 2'b11;
    frame_tick_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({btn_level_o, btn_press_o, btn_release_o, cmd_up_o, cmd_down_o} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b want 00000000", i,
                 {btn_level_o, btn_press_o, btn_release_o, cmd_up_o, cmd_down_o});
      end
      @(posedge clk);
      #1;
    end
    p0 = press_cnt0 + press_cnt1;
    rst = 1'b0;
    btn_i = 2'b00;
    wait_cycles(6);
    checks++;
    if (press_cnt0 + press_cnt1 != p0) begin
      errors++;
      $display("FAIL reset_release_pulse: got %0d presses want 0", press_cnt0 + press_cnt1 - p0);
    end
    p0 = press_cnt0;
    btn_i = 2'b01;
    t0 = cyc;
    wait_cycles(12);
    checks++;
    if (press_cnt0 - p0 != 1) begin
      errors++;
      $display("FAIL reset_press_count: got %0d want 1", press_cnt0 - p0);
    end
    checks++;
    if (press_cyc0 - t0 != 6) begin
      errors++;
      $display("FAIL reset_press_latency: got %0d want 6", press_cyc0 - t0);
    end
  endtask

  task automatic test_bounce();
    int t0, p0, r0;
    apply_reset();
    p0 = press_cnt0;
    r0 = rel_cnt0;
    btn_i = 2'b01; wait_cycles(2);
    btn_i = 2'b00; wait_cycles(2);
    btn_i = 2'b01; wait_cycles(2);
    btn_i = 2'b00; wait_cycles(2);
    btn_i = 2'b01;
    t0 = cyc;
    wait_cycles(14);
    checks++;
    if (press_cnt0 - p0 != 1) begin
      errors++;
      $display("FAIL bounce_press_count: got %0d want 1", press_cnt0 - p0);
    end
    checks++;
    if (press_cyc0 - t0 != 6) begin
      errors++;
      $display("FAIL bounce_press_latency: got %0d want 6", press_cyc0 - t0);
    end
    checks++;
    if (rel_cnt0 != r0) begin
      errors++;
      $display("FAIL bounce_release: got %0d releases want 0", rel_cnt0 - r0);
    end
  endtask

  task automatic test_frame_align();
    logic up, down;
    apply_reset();
    btn_i = 2'b01;
    wait_cycles(16);
    @(negedge clk);
    checks++;
    if (cmd_up_o !== 1'b0) begin
      errors++;
      $display("FAIL align_pre_tick: cmd_up got %b want 0", cmd_up_o);
    end
    checks++;
    if (btn_level_o !== 2'b01) begin
      errors++;
      $display("FAIL align_level: got %b want 01", btn_level_o);
    end
    @(posedge clk);
    #1;
    do_tick(up, down);
    checks++;
    if ({up, down} !== 2'b10) begin
      errors++;
      $display("FAIL align_tick1: up/down got %b want 10", {up, down});
    end
    @(negedge clk);
    checks++;
    if (cmd_up_o !== 1'b0) begin
      errors++;
      $display("FAIL align_post_tick: cmd_up got %b want 0", cmd_up_o);
    end
    wait_cycles(5);
    do_tick(up, down);
    checks++;
    if ({up, down} !== 2'b00) begin
      errors++;
      $display("FAIL align_tick2: up/down got %b want 00", {up, down});
    end
  endtask

  task automatic test_conflict();
    logic up, down;
    apply_reset();
    btn_i = 2'b01;
    wait_cycles(3);
    btn_i = 2'b11;
    wait_cycles(14);
    do_tick(up, down);
    checks++;
    if ({up, down} !== 2'b00) begin
      errors++;
      $display("FAIL conflict_tick: up/down got %b want 00", {up, down});
    end
    btn_i = 2'b01;
    wait_cycles(12);
    checks++;
    if (btn_level_o !== 2'b01) begin
      errors++;
      $display("FAIL conflict_level: got %b want 01", btn_level_o);
    end
    do_tick(up, down);
    checks++;
    if ({up, down} !== 2'b00) begin
      errors++;
      $display("FAIL conflict_pend_cleared: up/down got %b want 00", {up, down});
    end
  endtask

  task automatic test_repeat();
    logic up, down, exp;
    apply_reset();
    btn_i = 2'b10;
    wait_cycles(10);
    for (int t = 1; t <= 9; t++) begin
      do_tick(up, down);
      exp = (t % 2) == 1;
      checks++;
      if ({up, down} !== {1'b0, exp}) begin
        errors++;
        $display("FAIL repeat_tick%0d: up/down got %b want %b", t, {up, down}, {1'b0, exp});
      end
      wait_cycles(3);
    end
  endtask

  task automatic test_mid_reset();
    logic up, down;
    int r0, p0;
    apply_reset();
    r0 = rel_cnt0;
    btn_i = 2'b01;
    wait_cycles(10);
    btn_i = 2'b00;
    wait_cycles(12);
    checks++;
    if (rel_cnt0 - r0 != 1) begin
      errors++;
      $display("FAIL midrst_release: got %0d want 1", rel_cnt0 - r0);
    end
    p0 = press_cnt0;
    btn_i = 2'b01;
    wait_cycles(4);
    rst = 1'b1;
    btn_i = 2'b00;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(1);
    do_tick(up, down);
    checks++;
    if ({up, down} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_tick: up/down got %b want 00", {up, down});
    end
    checks++;
    if (btn_level_o !== 2'b00 || press_cnt0 != p0) begin
      errors++;
      $display("FAIL midrst_level: level got %b presses %0d want 00 and 0",
               btn_level_o, press_cnt0 - p0);
    end
  endtask

  task automatic test_enable();
    logic up, down;
    int t0, p0;
    apply_reset();
    p0 = press_cnt0;
    ena = 1'b0;
    btn_i = 2'b01;
    wait_cycles(8);
    checks++;
    if (btn_level_o !== 2'b00 || press_cnt0 != p0) begin
      errors++;
      $display("FAIL ena_low_hold: level got %b presses %0d want 00 and 0",
               btn_level_o, press_cnt0 - p0);
    end
    do_tick(up, down);
    checks++;
    if ({up, down} !== 2'b00) begin
      errors++;
      $display("FAIL ena_low_tick: up/down got %b want 00", {up, down});
    end
    ena = 1'b1;
    t0 = cyc;
    wait_cycles(8);
    checks++;
    if (press_cnt0 - p0 != 1 || press_cyc0 - t0 != 4) begin
      errors++;
      $display("FAIL ena_resume_press: count %0d latency %0d want 1 and 4",
               press_cnt0 - p0, press_cyc0 - t0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    btn_i = 2'b00;
    frame_tick_i = 1'b0;
    wait_cycles(2);
    test_reset();
    test_bounce();
    test_frame_align();
    test_conflict();
    test_repeat();
    test_mid_reset();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
